// File: rtl/paper_pkg.sv
// paper_pkg: shared definitions for the paper processor sequencer.
// Contents:
//   ADDR_W_DEF - default program-address width
//   OP_*       - 2-bit opcode constants (NOP, JNO, JMP, STP)
//   seq_state_t - sequencer FSM state encoding
package paper_pkg;

  localparam int ADDR_W_DEF = 5;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_JNO = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_STP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_JWAIT  = 3'd3,
    ST_STEP   = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_t;

endpackage

// File: rtl/wait_counter.sv
// wait_counter: bounded cycle counter used to time out the jump stage.
// Ports:
//   clk   in  clock
//   reset in  synchronous active-high reset
//   clr   in  clear count to zero (has priority over en)
//   en    in  count one cycle
//   tc    out high in the cycle whose increment brings the count to LIMIT,
//             i.e. the LIMIT-th counted cycle since the last clear
module wait_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_r;

  // Count register: clear wins over enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == CNT_LAST);

endmodule

// File: rtl/paper_sequencer.sv
// paper_sequencer: program counter and instruction-issue stage.
// Fetches {op, arg} words from a 1-cycle-latency program memory, executes
// NOP/JMP/STP locally and hands JNO to the external jump stage, waiting a
// bounded number of cycles for its enabling/enabling_sta result.
// Ports:
//   pulses       in  clock
//   reset        in  synchronous active-high reset
//   run          in  start request (honoured in IDLE/HALT only)
//   mem_addr     out program-memory read address
//   mem_data     in  instruction word {op[1:0], arg[ADDR_W-1:0]}
//   instruct     out opcode to jump stage (01 only while waiting on JNO)
//   enabling     in  jump stage has evaluated the JNO
//   enabling_sta in  jump taken
//   pc           out program counter
//   busy         out high outside IDLE/HALT
//   halted       out high in HALT
//   jno_err      out sticky jump-stage timeout flag
// All outputs are registered from the next-state values.
module paper_sequencer
  import paper_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int JNO_WAIT = 16
) (
  input  logic              pulses,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W+1:0] mem_data,
  output logic [1:0]        instruct,
  input  logic              enabling,
  input  logic              enabling_sta,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              jno_err
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  seq_state_t        state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W+1:0] ir_r, ir_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [1:0]        instruct_r, instruct_s;
  logic              busy_r, busy_s;
  logic              halted_r, halted_s;
  logic              jno_err_r, jno_err_s;
  logic              cnt_clr_s, cnt_en_s, cnt_tc_s;

  logic [1:0]        mem_op_s;
  logic [ADDR_W-1:0] mem_arg_s;
  logic [1:0]        ir_op_s;
  logic [ADDR_W-1:0] ir_arg_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign mem_op_s  = mem_data[ADDR_W+1:ADDR_W];
  assign mem_arg_s = mem_data[ADDR_W-1:0];
  assign ir_op_s   = ir_r[ADDR_W+1:ADDR_W];
  assign ir_arg_s  = ir_r[ADDR_W-1:0];
  // Unsigned ADDR_W-bit add: the last address wraps to 0.
  assign pc_inc_s  = pc_r + PC_ONE;

  wait_counter #(
    .LIMIT (JNO_WAIT)
  ) u_wait_counter (
    .clk   (pulses),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .tc    (cnt_tc_s)
  );

  // Next-state, next-PC and next-output decode.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    ir_s       = ir_r;
    mem_addr_s = mem_addr_r;
    jno_err_s  = jno_err_r;
    cnt_clr_s  = 1'b0;
    cnt_en_s   = 1'b0;

    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (run) begin
          state_s    = ST_FETCH;
          pc_s       = '0;
          mem_addr_s = '0;
          jno_err_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        // mem_addr already equals pc here; memory answers next cycle.
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        ir_s = mem_data;
        case (mem_op_s)
          OP_NOP: begin
            pc_s    = pc_inc_s;
            state_s = ST_STEP;
          end
          OP_JMP: begin
            pc_s    = mem_arg_s;
            state_s = ST_STEP;
          end
          OP_STP: begin
            state_s = ST_HALT;
          end
          OP_JNO: begin
            cnt_clr_s = 1'b1;
            state_s   = ST_JWAIT;
          end
          default: begin
            state_s = ST_IDLE;
          end
        endcase
      end
      ST_JWAIT: begin
        cnt_en_s = 1'b1;
        if (ir_op_s != OP_JNO) begin
          // Only a JNO can legally park us here; recover rather than hang.
          state_s = ST_IDLE;
        end else if (enabling) begin
          // A result arriving on the timeout cycle still counts as valid.
          pc_s    = enabling_sta ? ir_arg_s : pc_inc_s;
          state_s = ST_STEP;
        end else if (cnt_tc_s) begin
          jno_err_s = 1'b1;
          pc_s      = pc_inc_s;
          state_s   = ST_STEP;
        end else begin
          state_s = ST_JWAIT;
        end
      end
      ST_STEP: begin
        // pc already holds the next address; present it for the fetch.
        mem_addr_s = pc_r;
        state_s    = ST_FETCH;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are registered and
    // line up with that state. STEP forces instruct back to 00, giving the
    // jump stage a fresh rising edge for back-to-back JNOs.
    instruct_s = (state_s == ST_JWAIT) ? OP_JNO : OP_NOP;
    busy_s     = (state_s != ST_IDLE) && (state_s != ST_HALT);
    halted_s   = (state_s == ST_HALT);
  end

  // State, PC, IR and registered outputs.
  always_ff @(posedge pulses) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      pc_r       <= '0;
      ir_r       <= '0;
      mem_addr_r <= '0;
      instruct_r <= OP_NOP;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
      jno_err_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      ir_r       <= ir_s;
      mem_addr_r <= mem_addr_s;
      instruct_r <= instruct_s;
      busy_r     <= busy_s;
      halted_r   <= halted_s;
      jno_err_r  <= jno_err_s;
    end
  end

  assign mem_addr = mem_addr_r;
  assign instruct = instruct_r;
  assign pc       = pc_r;
  assign busy     = busy_r;
  assign halted   = halted_r;
  assign jno_err  = jno_err_r;

endmodule

// File: tb/tb_paper_sequencer.sv
// Testbench for paper_sequencer: program memory model, jump-stage model and
// a per-cycle scoreboard of expected registered outputs.
module tb_paper_sequencer;
  import paper_pkg::*;

  typedef struct packed {
    logic [4:0] addr;
    logic [1:0] ins;
    logic [4:0] pc;
    logic       busy;
    logic       halted;
    logic       err;
  } obs_t;

  logic       pulses;
  logic       reset;
  logic       run;
  logic [4:0] mem_addr;
  logic [6:0] mem_data;
  logic [1:0] instruct;
  logic       enabling;
  logic       enabling_sta;
  logic [4:0] pc;
  logic       busy;
  logic       halted;
  logic       jno_err;

  paper_sequencer #(.ADDR_W(5), .JNO_WAIT(16)) dut (
    .pulses       (pulses),
    .reset        (reset),
    .run          (run),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .instruct     (instruct),
    .enabling     (enabling),
    .enabling_sta (enabling_sta),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
    .jno_err      (jno_err)
  );

  initial pulses = 1'b0;
  always #5 pulses = ~pulses;

  // Program memory: synchronous read, one cycle latency.
  logic [6:0] mem [0:31];
  always @(posedge pulses) mem_data <= mem[mem_addr];

  // Jump stage: enabling rises once instruct has been 01 for jdelay edges.
  // jdelay == 0 models a stage that never answers.
  int jdelay = 0;
  int jcnt = 0;
  always @(posedge pulses) jcnt <= (instruct == 2'b01) ? jcnt + 1 : 0;
  assign enabling = (jdelay != 0) && (jcnt >= jdelay);

  // Counts 0->1 edges of instruct[0] as seen at the jump stage.
  int rises = 0;
  logic [1:0] ins_prev = 2'b00;
  always @(posedge pulses) begin
    if (instruct == 2'b01 && ins_prev != 2'b01) rises <= rises + 1;
    ins_prev <= instruct;
  end

  obs_t obs_now;
  assign obs_now = {mem_addr, instruct, pc, busy, halted, jno_err};

  obs_t q[$];
  obs_t exp_o;
  logic e_err;
  int tests_run = 0;
  int tests_failed = 0;
  int cyc;

  // ---------------- expectation builders (stimulus side) ----------------
  task automatic px(input logic [4:0] a, input logic [1:0] i, input logic [4:0] p,
                    input logic b, input logic h, input logic e);
    obs_t o;
    o = {a, i, p, b, h, e};
    q.push_back(o);
  endtask

  task automatic exp_nop(input logic [4:0] a);
    logic [4:0] n;
    n = a + 5'd1;
    px(a, 2'b00, a, 1'b1, 1'b0, e_err);
    px(a, 2'b00, a, 1'b1, 1'b0, e_err);
    px(a, 2'b00, n, 1'b1, 1'b0, e_err);
  endtask

  task automatic exp_jmp(input logic [4:0] a, input logic [4:0] t);
    px(a, 2'b00, a, 1'b1, 1'b0, e_err);
    px(a, 2'b00, a, 1'b1, 1'b0, e_err);
    px(a, 2'b00, t, 1'b1, 1'b0, e_err);
  endtask

  task automatic exp_stp(input logic [4:0] a, input int nhalt);
    px(a, 2'b00, a, 1'b1, 1'b0, e_err);
    px(a, 2'b00, a, 1'b1, 1'b0, e_err);
    for (int i = 0; i < nhalt; i++) px(a, 2'b00, a, 1'b0, 1'b1, e_err);
  endtask

  // k JWAIT cycles, then STEP with the resolved PC.
  task automatic exp_jno(input logic [4:0] a, input logic [4:0] t, input int k,
                         input logic taken, input logic timeout);
    logic [4:0] n;
    n = a + 5'd1;
    px(a, 2'b00, a, 1'b1, 1'b0, e_err);
    px(a, 2'b00, a, 1'b1, 1'b0, e_err);
    for (int i = 0; i < k; i++) px(a, 2'b01, a, 1'b1, 1'b0, e_err);
    if (timeout) e_err = 1'b1;
    px(a, 2'b00, taken ? t : n, 1'b1, 1'b0, e_err);
  endtask

  task automatic fill_mem;
    for (int i = 0; i < 32; i++) mem[i] = {OP_STP, 5'd0};
  endtask

  task automatic do_reset;
    @(negedge pulses) reset = 1'b1;
    @(negedge pulses) reset = 1'b0;
  endtask

  // Leaves the bench at the negedge of the first FETCH cycle.
  task automatic start;
    @(negedge pulses) run = 1'b1;
    @(negedge pulses) run = 1'b0;
    e_err = 1'b0;
    cyc = 0;
  endtask

  // ------------------------------ tests ---------------------------------
  task automatic test_reset;
    @(negedge pulses);
    reset = 1'b1;
    run = 1'b1;
    @(negedge pulses);
    tests_run++;
    if (obs_now !== obs_t'(15'd0)) begin
      tests_failed++;
      $display("FAIL reset_state: got %h expected %h", obs_now, 15'd0);
    end
    reset = 1'b0;
    run = 1'b0;
    @(negedge pulses);
    tests_run++;
    if (obs_now !== obs_t'(15'd0)) begin
      tests_failed++;
      $display("FAIL idle_hold: got %h expected %h", obs_now, 15'd0);
    end
  endtask

  task automatic test_nop_stp;
    fill_mem();
    mem[0] = {OP_NOP, 5'd0};
    mem[1] = {OP_NOP, 5'd0};
    mem[2] = {OP_STP, 5'd0};
    do_reset();
    start();
    exp_nop(5'd0);
    exp_nop(5'd1);
    exp_stp(5'd2, 3);
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      tests_run++;
      if (obs_now !== exp_o) begin
        tests_failed++;
        $display("FAIL nop_stp cyc%0d: got %h expected %h", cyc, obs_now, exp_o);
      end
      cyc++;
      @(negedge pulses);
    end
  endtask

  task automatic test_jmp;
    fill_mem();
    mem[0] = {OP_JMP, 5'd7};
    mem[1] = {OP_NOP, 5'd0};
    mem[7] = {OP_STP, 5'd0};
    do_reset();
    start();
    exp_jmp(5'd0, 5'd7);
    exp_stp(5'd7, 2);
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      tests_run++;
      if (obs_now !== exp_o) begin
        tests_failed++;
        $display("FAIL jmp cyc%0d: got %h expected %h", cyc, obs_now, exp_o);
      end
      cyc++;
      @(negedge pulses);
    end
  endtask

  // Resolves a JNO 12 at address 0 with the given jump-stage behaviour.
  task automatic test_jno(input string name, input int dly, input logic sta,
                          input int k, input logic taken, input logic timeout);
    logic [4:0] dest;
    fill_mem();
    mem[0]  = {OP_JNO, 5'd12};
    mem[1]  = {OP_STP, 5'd0};
    mem[12] = {OP_STP, 5'd0};
    jdelay = dly;
    enabling_sta = sta;
    do_reset();
    start();
    dest = taken ? 5'd12 : 5'd1;
    exp_jno(5'd0, 5'd12, k, taken, timeout);
    exp_stp(dest, 2);
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      tests_run++;
      if (obs_now !== exp_o) begin
        tests_failed++;
        $display("FAIL %s cyc%0d: got %h expected %h", name, cyc, obs_now, exp_o);
      end
      cyc++;
      @(negedge pulses);
    end
  endtask

  // Timeout leaves jno_err sticky through HALT; a new run clears it.
  task automatic test_rerun_clears_err;
    tests_run++;
    if (jno_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_sticky: got %b expected 1", jno_err);
    end
    mem[0] = {OP_STP, 5'd0};
    start();
    exp_stp(5'd0, 1);
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      tests_run++;
      if (obs_now !== exp_o) begin
        tests_failed++;
        $display("FAIL rerun cyc%0d: got %h expected %h", cyc, obs_now, exp_o);
      end
      cyc++;
      @(negedge pulses);
    end
  endtask

  task automatic test_wrap;
    fill_mem();
    mem[0]  = {OP_JMP, 5'd31};
    mem[31] = {OP_NOP, 5'd0};
    do_reset();
    start();
    exp_jmp(5'd0, 5'd31);
    exp_nop(5'd31);
    px(5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0);
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      tests_run++;
      if (obs_now !== exp_o) begin
        tests_failed++;
        $display("FAIL wrap cyc%0d: got %h expected %h", cyc, obs_now, exp_o);
      end
      cyc++;
      @(negedge pulses);
    end
  endtask

  task automatic test_back_to_back;
    int r0;
    fill_mem();
    mem[0] = {OP_JNO, 5'd2};
    mem[2] = {OP_JNO, 5'd5};
    mem[5] = {OP_STP, 5'd0};
    jdelay = 2;
    enabling_sta = 1'b1;
    do_reset();
    r0 = rises;
    start();
    exp_jno(5'd0, 5'd2, 3, 1'b1, 1'b0);
    exp_jno(5'd2, 5'd5, 3, 1'b1, 1'b0);
    exp_stp(5'd5, 2);
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      tests_run++;
      if (obs_now !== exp_o) begin
        tests_failed++;
        $display("FAIL b2b cyc%0d: got %h expected %h", cyc, obs_now, exp_o);
      end
      cyc++;
      @(negedge pulses);
    end
    tests_run++;
    if (rises - r0 !== 2) begin
      tests_failed++;
      $display("FAIL b2b_edges: got %0d expected 2", rises - r0);
    end
  endtask

  task automatic test_reset_mid_jwait;
    obs_t jw;
    fill_mem();
    mem[0] = {OP_JNO, 5'd12};
    jdelay = 0;
    enabling_sta = 1'b1;
    do_reset();
    start();
    exp_jno(5'd0, 5'd12, 5, 1'b0, 1'b0);
    void'(q.pop_back());  // stop before the JNO resolves
    while (q.size() > 0) begin
      exp_o = q.pop_front();
      tests_run++;
      if (obs_now !== exp_o) begin
        tests_failed++;
        $display("FAIL mid_jwait cyc%0d: got %h expected %h", cyc, obs_now, exp_o);
      end
      cyc++;
      @(negedge pulses);
    end
    // run while busy must not restart the program.
    jw = {5'd0, 2'b01, 5'd0, 1'b1, 1'b0, 1'b0};
    run = 1'b1;
    @(negedge pulses);
    run = 1'b0;
    tests_run++;
    if (obs_now !== jw) begin
      tests_failed++;
      $display("FAIL run_ignored: got %h expected %h", obs_now, jw);
    end
    reset = 1'b1;
    @(negedge pulses);
    reset = 1'b0;
    tests_run++;
    if (obs_now !== obs_t'(15'd0)) begin
      tests_failed++;
      $display("FAIL reset_jwait: got %h expected %h", obs_now, 15'd0);
    end
    @(negedge pulses);
    tests_run++;
    if (obs_now !== obs_t'(15'd0)) begin
      tests_failed++;
      $display("FAIL reset_jwait_idle: got %h expected %h", obs_now, 15'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    enabling_sta = 1'b0;
    e_err = 1'b0;
    cyc = 0;
    fill_mem();
    test_reset();
    test_nop_stp();
    test_jmp();
    test_jno("jno_taken", 9, 1'b1, 10, 1'b1, 1'b0);
    test_jno("jno_not_taken", 9, 1'b0, 10, 1'b0, 1'b0);
    test_jno("jno_timeout", 0, 1'b1, 16, 1'b0, 1'b1);
    test_rerun_clears_err();
    test_jno("jno_tie", 15, 1'b1, 16, 1'b1, 1'b0);
    test_wrap();
    test_back_to_back();
    test_reset_mid_jwait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/paper_sequencer.md
# paper_sequencer

Program-counter and instruction-issue stage of the paper processor. It fetches instruction words from program memory and drives the 2-bit `instruct` code into the JNO jump stage. It then consumes that stage's `enabling`/`enabling_sta` result to decide the next PC. It handles NOP, unconditional jump and halt itself, and enforces a bounded wait on the jump stage.

## Interface
Parameters:
- `ADDR_W`, 5, program-address width; PC wraps modulo 2^ADDR_W
- `JNO_WAIT`, 16, maximum cycles spent in JWAIT before timeout (≥2)

Ports:
- `pulses`  in  1  clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `run`  in  1  start request; honoured only in IDLE or HALT
- `mem_addr`  out  ADDR_W  program-memory read address
- `mem_data`  in  2+ADDR_W  instruction word {op[1:0], arg[ADDR_W-1:0]}; valid one cycle after `mem_addr`
- `instruct`  out  2  opcode presented to the jump stage
- `enabling`  in  1  jump stage has evaluated the JNO
- `enabling_sta`  in  1  jump taken (status clear)
- `pc`  out  ADDR_W  current program counter
- `busy`  out  1  high in every state except IDLE and HALT
- `halted`  out  1  high in HALT
- `jno_err`  out  1  sticky JNO timeout flag, cleared by `reset` or accepted `run`

## Operation
- Opcodes: 00 NOP, 01 JNO, 10 JMP, 11 STP.
- States: IDLE, FETCH, DECODE, JWAIT, STEP, HALT.
- Reset values:
  - state IDLE
  - `pc`=0, `mem_addr`=0, `instruct`=00
  - `busy`=0, `halted`=0, `jno_err`=0
  - instruction register 0, wait counter 0
- IDLE/HALT + `run`: set `pc`=0, clear `jno_err`, go to FETCH. Otherwise stay.
- FETCH: `mem_addr`=`pc`; go to DECODE.
- DECODE: latch `mem_data` into IR.
  - NOP: next PC = `pc`+1; go to STEP.
  - JMP: next PC = arg; go to STEP.
  - STP: `pc` unchanged; go to HALT.
  - JNO: `instruct`=01 from the next cycle; clear wait counter; go to JWAIT.
- JWAIT: hold `instruct`=01 and increment the wait counter each cycle.
  - First cycle with `enabling`=1: `pc` = arg if `enabling_sta`=1, else `pc`+1; go to STEP.
  - If the counter reaches `JNO_WAIT` with `enabling` still 0: set `jno_err`, `pc`=`pc`+1 (treated as not taken), go to STEP.
  - `enabling_sta` is ignored while `enabling`=0.
- STEP: `instruct`=00 (guarantees a fresh 0→1 edge for back-to-back JNOs); go to FETCH.
- `instruct` is 00 in all states except JWAIT.
- PC arithmetic is unsigned ADDR_W bits; `pc`+1 at 2^ADDR_W−1 wraps to 0.
- `run` while busy is ignored.
- `reset` in any state, including mid-JWAIT, forces reset values on the next edge. The pending jump result is discarded.
- `enabling` and timeout in the same cycle: `enabling` wins and `jno_err` is not set.

## Timing
- NOP/JMP: 3 cycles per instruction (FETCH, DECODE, STEP).
- STP: HALT is entered 2 cycles after FETCH.
- JNO: 3 + k cycles, where k = JWAIT cycles until `enabling` (1 ≤ k ≤ `JNO_WAIT`).
- The jump stage needs ≥9 `pulses` after the `instruct` rising edge, so `JNO_WAIT` must cover its latency.
- Memory read latency is fixed at 1 cycle; there is no stall input.
- All outputs are registered; no combinational input→output paths.

## Structure
- Shared package `paper_pkg`: opcode constants (`OP_NOP`, `OP_JNO`, `OP_JMP`, `OP_STP`), sequencer state enum, default `ADDR_W`.
- One sub-module, `wait_counter`: clear, enable, terminal-count output at `JNO_WAIT`.
- PC/IR registers and FSM sit in `paper_sequencer`.

## Test plan
- Reset, then `run`; memory {NOP, NOP, STP} → `mem_addr` 0,1,2; `halted`=1 at cycle 8; `pc`=2.
- JMP 7 at addr 0, STP at 7 → `pc`=7, HALT; address 1 never fetched.
- JNO 12 with `enabling` after 9 cycles:
  - `enabling_sta`=1 → `pc`=12
  - `enabling_sta`=0 → `pc`=1
  - in both cases `instruct`=01 only during JWAIT, then 00 for ≥1 cycle.
- JNO with `enabling` never asserted, `JNO_WAIT`=16 → `jno_err`=1 after 16 JWAIT cycles; `pc`=1; execution continues.
- NOP at address 31 (`ADDR_W`=5) → `pc` wraps to 0. Two consecutive JNOs each produce a separate 0→1 edge on `instruct`.
- `reset` asserted mid-JWAIT → next cycle IDLE, `pc`=0, `instruct`=00, `busy`=0. `run` while busy → ignored.
